// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states and widths.
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_MUL   = 4'd2,
      OP_DIV   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_SLT   = 4'd7,
      OP_SLL   = 4'd8,
      OP_SRL   = 4'd9,
      OP_ILL10 = 4'd10,
      OP_ILL11 = 4'd11,
      OP_ILL12 = 4'd12,
      OP_ILL13 = 4'd13,
      OP_ILL14 = 4'd14,
      OP_ILL15 = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: WIDTH-step shift-add multiplier and restoring divider sharing
// one 2*WIDTH accumulator; lo/hi present the value the current step will produce.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0]   opnd;
   logic [CW-1:0]      count;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     part;
   logic [WIDTH:0]     diff;

   // acc = {partial/remainder, multiplier/dividend}; both algorithms start from {0, a}
   always_comb begin
      part = acc[2*WIDTH-1:WIDTH-1];
      diff = part - {1'b0, opnd};
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      if (is_div) begin
         if (diff[WIDTH])
            acc_nx = {acc[2*WIDTH-2:0], 1'b0};
         else
            acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = {sum, acc[WIDTH-1:1]};
      end
   end

   assign lo   = acc_nx[WIDTH-1:0];
   assign hi   = acc_nx[2*WIDTH-1:WIDTH];
   assign last = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         opnd  <= '0;
         count <= '0;
      end else if (load) begin
         acc   <= {{WIDTH{1'b0}}, a};
         opnd  <= b;
         count <= '0;
      end else if (step) begin
         acc   <= acc_nx;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: start/busy/done FSM, single-cycle datapath and registered
// result/flag outputs; MUL and DIV are delegated to the iterative engine.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             busy,
   output logic             done
);

   localparam int SH_W = $clog2(WIDTH);

   state_e           state;
   op_e              op_in;
   logic             accept;
   logic             go_mul;
   logic             go_div;
   logic             eng_step;
   logic             eng_is_div;
   logic             eng_last;
   logic [WIDTH-1:0] eng_lo;
   logic [WIDTH-1:0] eng_hi;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [WIDTH-1:0] bas_res;
   logic [WIDTH-1:0] bas_hi;
   logic             bas_ov;
   logic             bas_dbz;

   assign op_in      = op_e'(op);
   assign accept     = (state == ST_IDLE) && start;
   assign go_mul     = accept && (op_in == OP_MUL);
   assign go_div     = accept && (op_in == OP_DIV) && (b != '0);
   assign eng_step   = (state == ST_MUL) || (state == ST_DIV);
   assign eng_is_div = (state == ST_DIV) || go_div;
   assign add_res    = a + b;
   assign sub_res    = a - b;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (go_mul || go_div),
      .step   (eng_step),
      .is_div (eng_is_div),
      .a      (a),
      .b      (b),
      .lo     (eng_lo),
      .hi     (eng_hi),
      .last   (eng_last)
   );

   // DIV only reaches this path when b==0; MUL never does
   always_comb begin
      bas_res = '0;
      bas_hi  = '0;
      bas_ov  = 1'b0;
      bas_dbz = 1'b0;
      case (op_in)
         OP_ADD: begin
            bas_res = add_res;
            bas_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            bas_res = sub_res;
            bas_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_DIV: begin
            bas_res = '1;
            bas_hi  = a;
            bas_dbz = 1'b1;
         end
         OP_AND:  bas_res = a & b;
         OP_OR:   bas_res = a | b;
         OP_XOR:  bas_res = a ^ b;
         OP_SLT:  bas_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  bas_res = a << b[SH_W-1:0];
         OP_SRL:  bas_res = a >> b[SH_W-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         result      <= '0;
         hi          <= '0;
         zero        <= 1'b1;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (go_mul) begin
                     state <= ST_MUL;
                  end else if (go_div) begin
                     state <= ST_DIV;
                  end else begin
                     state       <= ST_DONE;
                     done        <= 1'b1;
                     result      <= bas_res;
                     hi          <= bas_hi;
                     zero        <= (bas_res == '0);
                     overflow    <= bas_ov;
                     div_by_zero <= bas_dbz;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (eng_last) begin
                  state       <= ST_DONE;
                  done        <= 1'b1;
                  result      <= eng_lo;
                  hi          <= eng_hi;
                  zero        <= (eng_lo == '0);
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, multi-cycle corner
// sequences and random operations checked against an arithmetic reference model.
module tb_alu_mc;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [W-1:0]  result;
   logic [W-1:0]  hi;
   logic          zero;
   logic          overflow;
   logic          div_by_zero;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .result      (result),
      .hi          (hi),
      .zero        (zero),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         zero;
      logic         ov;
      logic         dbz;
      int           lat;
      bit           noise;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference behaviour from the operation definitions, using plain arithmetic
   function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic [W-1:0] h,
                                 output logic ov, output logic dz);
      logic [63:0] p;
      r = '0; h = '0; ov = 1'b0; dz = 1'b0;
      case (o)
         4'd0: begin r = x + y; ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
         4'd1: begin r = x - y; ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
         4'd2: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; h = p[63:32]; end
         4'd3: begin
            if (y == 0) begin r = '1; h = x; dz = 1'b1; end
            else begin r = x / y; h = x % y; end
         end
         4'd4: r = x & y;
         4'd5: r = x | y;
         4'd6: r = x ^ y;
         4'd7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd8: r = x << y[4:0];
         4'd9: r = x >> y[4:0];
         default: ;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic [W-1:0] eh, input logic ez, input logic eov,
                         input logic edbz, input int elat, input bit noise);
      logic [W-1:0] prev_res, prev_hi;
      int  cyc;
      bit  stable;
      prev_res = result;
      prev_hi  = hi;
      stable   = 1'b1;
      op = o; a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      if (noise) begin op = 4'd0; a = $urandom; b = $urandom; end
      else start = 1'b0;
      while (!done && cyc < 100) begin
         if (result !== prev_res || hi !== prev_hi) stable = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (noise) begin a = $urandom; b = $urandom; end
      end
      chk({tag, " done_seen"}, 64'(done), 64'd1);
      chk({tag, " latency"}, 64'(cyc), 64'(elat));
      chk({tag, " result"}, 64'(result), 64'(er));
      chk({tag, " hi"}, 64'(hi), 64'(eh));
      chk({tag, " zero"}, 64'(zero), 64'(ez));
      chk({tag, " overflow"}, 64'(overflow), 64'(eov));
      chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
      chk({tag, " busy_in_done"}, 64'(busy), 64'd1);
      if (elat > 1) chk({tag, " outputs_held"}, 64'(stable), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " idle_done"}, 64'(done), 64'd0);
      chk({tag, " idle_busy"}, 64'(busy), 64'd0);
      chk({tag, " idle_result"}, 64'(result), 64'(er));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " result"}, 64'(result), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'd0);
      chk({tag, " zero"}, 64'(zero), 64'd1);
      chk({tag, " overflow"}, 64'(overflow), 64'd0);
      chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb, er, eh;
      logic         eov, edz;
      int           lat;
      bit           saw_done;

      vt[0]  = '{4'd0,  32'd5,          32'd7,          32'd12,         32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[1]  = '{4'd0,  32'h7FFFFFFF,   32'd1,          32'h80000000,   32'd0, 1'b0, 1'b1, 1'b0, 1,  1'b0};
      vt[2]  = '{4'd1,  32'd3,          32'd3,          32'd0,          32'd0, 1'b1, 1'b0, 1'b0, 1,  1'b0};
      vt[3]  = '{4'd1,  32'h80000000,   32'd1,          32'h7FFFFFFF,   32'd0, 1'b0, 1'b1, 1'b0, 1,  1'b0};
      vt[4]  = '{4'd2,  32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'd1, 1'b0, 1'b0, 1'b0, 33, 1'b1};
      vt[5]  = '{4'd3,  32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 1'b0, 1'b0, 33, 1'b1};
      vt[6]  = '{4'd3,  32'd9,          32'd0,          32'hFFFFFFFF,   32'd9, 1'b0, 1'b0, 1'b1, 1,  1'b1};
      vt[7]  = '{4'd7,  32'hFFFFFFFF,   32'd1,          32'd1,          32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[8]  = '{4'd8,  32'd1,          32'd31,         32'h80000000,   32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[9]  = '{4'd9,  32'h80,         32'h23,         32'h10,         32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[10] = '{4'd12, 32'd5,          32'd6,          32'd0,          32'd0, 1'b1, 1'b0, 1'b0, 1,  1'b0};
      vt[11] = '{4'd4,  32'hF0F0,       32'hFF00,       32'hF000,       32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[12] = '{4'd6,  32'hF0F0,       32'hFF00,       32'h0FF0,       32'd0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
      vt[13] = '{4'd7,  32'd1,          32'hFFFFFFFF,   32'd0,          32'd0, 1'b1, 1'b0, 1'b0, 1,  1'b0};

      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      @(posedge clk); @(posedge clk); #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].hi,
                vt[i].zero, vt[i].ov, vt[i].dbz, vt[i].lat, vt[i].noise);

      // Reset at cycle 10 of a multiply aborts it with no done pulse
      op = 4'd2; a = 32'h12345; b = 32'h6789; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset_values("abort");
      chk("abort no_early_done", 64'(saw_done), 64'd0);
      @(posedge clk); #1;
      chk("abort stays_idle", 64'(busy), 64'd0);
      run_op("post_abort_add", 4'd0, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      run_op("post_abort_mul", 4'd2, 32'h12345, 32'h6789, 32'h12345 * 32'h6789, 32'd0,
             1'b0, 1'b0, 1'b0, 33, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 40);
         if ($urandom_range(0, 7) == 0) rb = '0;
         model(ro, ra, rb, er, eh, eov, edz);
         lat = (ro == 4'd2 || (ro == 4'd3 && rb != 0)) ? 33 : 1;
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, er, eh, (er == 0), eov, edz,
                lat, ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the next-generation datapath. It replaces the purely combinational ALU with a registered block: logic, add and shift operations complete in one cycle, while multiply and divide run iteratively over WIDTH cycles. A start/busy/done handshake sequences operations. It also produces a full-width product and remainder, a signed overflow flag and a divide-by-zero flag.

## Interface
- WIDTH, 32: operand and result width; must be at least 4 and a power of two.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low. Sampled on rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- op  in  4  operation code, captured with start.
- a, b  in  WIDTH  operands, captured with start.
- result  out  WIDTH  low word of the result; holds its value until the next completion.
- hi  out  WIDTH  upper product word (MUL) or remainder (DIV); 0 for all other ops.
- zero  out  1  result==0 (low word only), registered with result.
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- div_by_zero  out  1  set on a DIV with b==0.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result, hi and flags are valid and stable from this cycle on.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 MUL (unsigned, 2·WIDTH product), 3 DIV (unsigned quotient/remainder).
  - 4 AND, 5 OR, 6 XOR.
  - 7 SLT (signed a<b → 1, else 0).
  - 8 SLL, 9 SRL: a shifted by b[log2(WIDTH)-1:0].
  - 10–15 illegal: result=0, hi=0, flags 0; completes like a basic op.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE & start & op==MUL → MUL; counter=0, accumulator cleared, operands latched.
  - IDLE & start & op==DIV & b!=0 → DIV; restoring divider, one quotient bit per cycle, MSB first.
  - IDLE & start & any other op (including DIV with b==0) → DONE; result computed and registered on the accepting edge.
  - MUL/DIV: counter increments each cycle; at counter==WIDTH-1 → DONE with final values registered.
  - DONE → IDLE unconditionally; done=1 only in DONE.
- Divide by zero: result = all ones, hi = a, div_by_zero=1.
- Overflow: set when the operand signs dictate it, i.e. ADD with equal signs whose result sign differs, or SUB with differing signs whose result sign differs from a.
- ADD/SUB wrap modulo 2^WIDTH.
- start while busy=1 (including in DONE) is ignored; a, b and op are not re-sampled.
- Outputs do not change during MUL/DIV; they update only on the edge entering DONE.

## Timing
- Reset (rst_n=0 on an edge): state=IDLE, counter=0, result=0, hi=0, zero=1, overflow=0, div_by_zero=0, busy=0, done=0.
- Reset mid-operation aborts the operation immediately, with no done pulse.
- Latency from the accepting edge to done high:
  - basic op or DIV by zero: 1 cycle;
  - MUL/DIV: WIDTH+1 cycles.
- Throughput: the earliest next start is accepted on the edge where state returns to IDLE, i.e. the cycle after done.
  - Back-to-back basic ops therefore run every 2 cycles.

## Structure
- Shared package alu_pkg:
  - op_e enum with the 16 codes;
  - state_e enum (IDLE, MUL, DIV, DONE);
  - OP_W=4 constant.
- Sub-module alu_muldiv_iter holds the WIDTH-step shift-add/restoring engine, iteration counter and 2·WIDTH accumulator.
  - Its controls are load, step and is_div; its outputs are lo and hi.
- The top level holds the FSM, the single-cycle datapath and the flag and output registers.

## Test plan
- Reset then idle: outputs match the reset values; ADD 5+7 → done 1 cycle later, result=12, zero=0, busy low the following cycle.
- ADD 0x7FFFFFFF+1 → result=0x80000000, overflow=1; SUB 3−3 → result=0, zero=1, overflow=0.
- MUL 0xFFFFFFFF×2 → done at WIDTH+1=33 cycles, result=0xFFFFFFFE, hi=1; start pulses mid-operation ignored.
- DIV 100/7 → result=14, hi=2 after 33 cycles; DIV 9/0 → 1 cycle later, result=0xFFFFFFFF, hi=9, div_by_zero=1.
- SLT −1<1 → 1; SLL 1 by 31 → 0x80000000; SRL with b=0x23 shifts by 3; op=12 → result 0, zero=1.
- MUL started, rst_n low at cycle 10 → next cycle all outputs at reset values, no done; a new ADD then completes normally.
